// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and elaboration-time helpers for the
// rotation-mode CORDIC sin/cos generator.
package cordic_pkg;

    // CORDIC gain compensation 1/prod(sqrt(1+2^-2i)) = 0.6072529350, Q1.30
    localparam int unsigned K_FRAC = 30;
    localparam logic [31:0] K_Q    = 32'd652032875;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Top two phase bits selecting the +/-pi/2 pre-rotation
    localparam logic [1:0] QUAD_POS_HALF = 2'b01;
    localparam logic [1:0] QUAD_NEG_HALF = 2'b10;

    // Starting x magnitude: round(ampl * K)
    function automatic logic [31:0] calc_x0(input int unsigned ampl);
        logic [63:0] prod;
        prod = 64'(ampl) * 64'(K_Q);
        prod = prod + (64'd1 << (K_FRAC - 1));
        return 32'(prod >> K_FRAC);
    endfunction

    // atan(2^-idx)/pi, rounded to frac_bits fractional bits (frac_bits <= 31)
    function automatic logic [31:0] atan_pi_q(input int unsigned idx, input int unsigned frac_bits);
        logic [31:0] q31;
        logic [63:0] v;
        case (idx)
            0:       q31 = 32'd536870912;
            1:       q31 = 32'd316933406;
            2:       q31 = 32'd167458907;
            3:       q31 = 32'd85004763;
            4:       q31 = 32'd42667331;
            5:       q31 = 32'd21354465;
            6:       q31 = 32'd10679837;
            7:       q31 = 32'd5340245;
            8:       q31 = 32'd2670163;
            9:       q31 = 32'd1335086;
            10:      q31 = 32'd667544;
            11:      q31 = 32'd333772;
            12:      q31 = 32'd166886;
            13:      q31 = 32'd83443;
            14:      q31 = 32'd41722;
            15:      q31 = 32'd20861;
            16:      q31 = 32'd10430;
            17:      q31 = 32'd5215;
            18:      q31 = 32'd2608;
            19:      q31 = 32'd1304;
            20:      q31 = 32'd652;
            21:      q31 = 32'd326;
            22:      q31 = 32'd163;
            23:      q31 = 32'd81;
            default: q31 = 32'd0;
        endcase
        if (frac_bits >= 31) begin
            v = 64'(q31);
        end else begin
            v = (64'(q31) + (64'd1 << (30 - frac_bits))) >> (31 - frac_bits);
        end
        return 32'(v);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// atan(2^-i)/pi table with one cycle of read latency.
// ROM_FILE names the table image; contents are generated at elaboration from
// the same atan/pi definition, and an empty name yields an all-zero table.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 16,
    parameter              ROM_FILE = "atan_pi_rom.hex"
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          HAS_IMAGE = |ROM_FILE;

    logic [DATA_W-1:0] w_table [DEPTH];
    logic [DATA_W-1:0] r_data;

    // Constant table, one entry per iteration
    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        assign w_table[g] = HAS_IMAGE ? DATA_W'(atan_pi_q(g, DATA_W - 1)) : '0;
    end

    // Registered read; addresses past the table return zero
    always_ff @(posedge clk) begin
        if (i_addr < ADDR_W'(DEPTH)) begin
            r_data <= w_table[IDX_W'(i_addr)];
        end else begin
            r_data <= '0;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: phase (angle/pi) -> (AMPL*cos, AMPL*sin).
// Optional macro SINCOS_SAT_EN: clamp x/y to the output range instead of
// truncating to the low DOUT_WIDTH bits.
module cordic_sincos
    import cordic_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = 16,
    parameter int unsigned DOUT_WIDTH = 16,
    parameter int unsigned ITER       = 16,
    parameter int unsigned AMPL       = 32000,
    parameter              ROM_FILE   = "atan_pi_rom.hex"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIN_WIDTH-1:0]  phase,
    input  logic                  din_valid,
    output logic                  sys_ready,
    output logic [DOUT_WIDTH-1:0] cos_out,
    output logic [DOUT_WIDTH-1:0] sin_out,
    output logic                  dout_valid
);

    localparam int unsigned XY_W  = DOUT_WIDTH + 2;
    localparam int unsigned Z_W   = DIN_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(ITER + 1);

    localparam logic signed [XY_W-1:0] X0     = XY_W'(calc_x0(AMPL));
    localparam logic signed [Z_W-1:0]  Z_HALF = Z_W'(64'd1 << (DIN_WIDTH - 2));
`ifdef SINCOS_SAT_EN
    localparam logic signed [XY_W-1:0] SAT_MAX = XY_W'((64'd1 << (DOUT_WIDTH - 1)) - 64'd1);
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_accept;
    logic [CNT_W-1:0]        w_rom_addr;
    logic [CNT_W-1:0]        r_cnt;
    logic [DIN_WIDTH-1:0]    w_atan;
    logic signed [Z_W-1:0]   w_atan_z;
    logic signed [Z_W-1:0]   w_phase_z;
    logic [1:0]              w_top2;
    logic                    w_dir;
    logic signed [XY_W-1:0]  w_xs;
    logic signed [XY_W-1:0]  w_ys;
    logic signed [XY_W-1:0]  r_x;
    logic signed [XY_W-1:0]  r_y;
    logic signed [Z_W-1:0]   r_z;
    logic [DOUT_WIDTH-1:0]   r_cos;
    logic [DOUT_WIDTH-1:0]   r_sin;
    logic                    r_valid;
    logic                    r_ready;

    // Reduce internal x/y to the output width
    function automatic logic [DOUT_WIDTH-1:0] narrow(input logic signed [XY_W-1:0] v);
`ifdef SINCOS_SAT_EN
        if (v > SAT_MAX) begin
            return DOUT_WIDTH'(SAT_MAX);
        end
        if (v < -SAT_MAX) begin
            return DOUT_WIDTH'(-SAT_MAX);
        end
`endif
        return DOUT_WIDTH'(v);
    endfunction

    cordic_atan_rom #(
        .DEPTH    (ITER),
        .ADDR_W   (CNT_W),
        .DATA_W   (DIN_WIDTH),
        .ROM_FILE (ROM_FILE)
    ) u_atan_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_data (w_atan)
    );

    assign w_top2    = phase[DIN_WIDTH-1 -: 2];
    assign w_phase_z = {phase[DIN_WIDTH-1], phase};
    assign w_atan_z  = {1'b0, w_atan};
    assign w_dir     = ~r_z[Z_W-1];
    assign w_xs      = r_x >>> r_cnt;
    assign w_ys      = r_y >>> r_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, accept decode and ROM address (one entry ahead of the iteration)
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rom_addr  = '0;
        case (r_state)
            IDLE: begin
                w_accept = din_valid & r_ready;
                if (w_accept) begin
                    w_state_nxt = ROT;
                end
            end
            ROT: begin
                w_rom_addr = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(ITER - 1)) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: quadrant pre-rotation, micro-rotations, output capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            r_ready <= (w_state_nxt == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        case (w_top2)
                            QUAD_POS_HALF: begin
                                r_x <= '0;
                                r_y <= X0;
                                r_z <= w_phase_z - Z_HALF;
                            end
                            QUAD_NEG_HALF: begin
                                r_x <= '0;
                                r_y <= -X0;
                                r_z <= w_phase_z + Z_HALF;
                            end
                            default: begin
                                r_x <= X0;
                                r_y <= '0;
                                r_z <= w_phase_z;
                            end
                        endcase
                    end
                end
                ROT: begin
                    if (w_dir) begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan_z;
                    end else begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan_z;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                OUT: begin
                    r_cos   <= narrow(r_x);
                    r_sin   <= narrow(r_y);
                    r_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sys_ready  = r_ready;
    assign cos_out    = r_cos;
    assign sin_out    = r_sin;
    assign dout_valid = r_valid;

endmodule
